io_seq_gen: RTL
===============

// Module: io_seq_gen
// PURPOSE
//  Produces the 16-bit output value that feeds one io_pins bank (reg_0..reg_3).
//  Holds a serial-programmed static value. Also plays back a 16-entry
//  {dwell,value} pattern table, started by a trigger pulse (radar T/R and
//  blanking gates). Sits between the serial register bus and io_pins; one
//  instance per bank.
// PARAMETERS
//  ADDR_CTRL    7'd64  serial addr: [0]=enable, [1]=loop, [7:4]=last_idx
//  ADDR_STATIC  7'd65  serial addr: [31:16]=mask, [15:0]=value (masked update)
//  ADDR_WPTR    7'd66  serial addr: [3:0]=pattern write pointer
//  ADDR_WDATA   7'd67  serial addr: [31:16]=dwell, [15:0]=value; writes entry
//  DEPTH        16     pattern entries (power of 2; pointers log2(DEPTH) bits)
// PORTS
//  clock          in   1   system clock; all logic on posedge
//  reset          in   1   synchronous, active-high reset
//  serial_addr    in   7   serial register address
//  serial_data    in   32  serial register data
//  serial_strobe  in   1   one-cycle write strobe
//  trigger        in   1   one-cycle start pulse (level is not edge-detected)
//  reg_out        out  16  value to io_pins reg_N
//  busy           out  1   high while state==RUN
//  step_idx       out  4   index of entry currently driven (0 when not RUN)
//  done           out  1   one-cycle pulse at end of non-loop playback
// BEHAVIOUR
//  Reset: ctrl=0, static_val=0, wptr=0, state=IDLE, reg_out=0, busy=0,
//   step_idx=0, done=0, dwell counter=0. Pattern RAM is not reset.
//  Serial writes are decoded only when serial_strobe=1; other addresses are ignored.
//  - STATIC: static_val <= (static_val & ~d[31:16]) | (d[15:0] & d[31:16]).
//  - WDATA: mem[wptr] <= d; wptr <= wptr+1 (wraps 15->0).
//  - WPTR: wptr <= d[3:0].
//  - A WDATA write during RUN is allowed. It takes effect the next time that entry loads.
//  FSM: IDLE, ARMED, RUN.
//  - IDLE: reg_out=static_val. Go to ARMED when ctrl.enable=1.
//  - ARMED: reg_out=static_val. On trigger, at that edge:
//    reg_out<=mem[0].value, cnt<=max(mem[0].dwell,1)-1, step_idx<=0, go to RUN.
//    reg_out therefore changes 1 cycle after trigger is sampled.
//  - RUN: each entry is held exactly max(dwell,1) cycles, so dwell=0 acts as 1.
//    If cnt!=0: cnt--.
//    If cnt==0 and step_idx!=last_idx: load entry step_idx+1 the same way.
//    If cnt==0 and step_idx==last_idx:
//      loop=1 -> load entry 0 with no gap cycle.
//      loop=0 -> go to ARMED, reg_out<=static_val, done<=1 for 1 cycle.
//  - trigger while in RUN is ignored; there is no restart.
//  - ctrl.enable=0 in any state -> IDLE at the next edge, reg_out<=static_val.
//    No done pulse is produced.
//  - last_idx is sampled live. Lowering it below step_idx mid-run ends or loops
//    when the count wraps past 15->0; raising it extends the run.
//  - In IDLE/ARMED, a STATIC write is visible on reg_out the next cycle.
//  - Simultaneous STATIC write and sequence end: the new static_val is output.
//  - reset wins over every other event, including mid-RUN.
//  Widths: dwell is 16 bits unsigned. Maximum entry duration is 65535 cycles;
//   total run is the sum of the entry durations.
// STRUCTURE
//  - Add FR_IO_SEQ_* address defines to fpga_regs_standard.v and pass them as
//    parameter overrides at instantiation. FSM state encodings are localparams.
//  - Sub-module io_seq_mem: DEPTH x 32 RAM, synchronous write, asynchronous
//    read (distributed RAM).
//  - Top level holds the serial decode, static register, FSM and dwell counter.
// TESTING
//  1 Reset; write STATIC 0x00FF_00A5 -> reg_out=0x00A5 next cycle; busy=0, done=0.
//  2 Masked update: write 0x0F00_0F00 after test 1 -> reg_out=0x0FA5; unmasked bits unchanged.
//  3 Write entries {3,0x0001},{0,0x0002},{2,0x0004}; ctrl=0x21 (enable, last_idx=2);
//    trigger -> reg_out 0x0001 x3, 0x0002 x1, 0x0004 x2; then static value; done=1 for 1 cycle.
//  4 Same pattern with loop=1 (ctrl=0x23) -> sequence repeats with no gap;
//    a second trigger mid-run is ignored; busy stays 1.
//  5 Clear enable mid-entry -> next cycle state=IDLE, reg_out=static, busy=0, no done pulse.
//  6 Assert reset mid-RUN -> all outputs 0 next cycle; later trigger ignored until enable is rewritten.

Source files
------------

// File: rtl/io_seq_gen_pkg.sv
// Shared types and defaults for the io_seq_gen pattern sequencer.
// Holds the register address defaults, the FSM state enum and the entry/ctrl layouts.
package io_seq_gen_pkg;

  localparam logic [6:0] DEF_ADDR_CTRL   = 7'd64;
  localparam logic [6:0] DEF_ADDR_STATIC = 7'd65;
  localparam logic [6:0] DEF_ADDR_WPTR   = 7'd66;
  localparam logic [6:0] DEF_ADDR_WDATA  = 7'd67;

  localparam int DEPTH = 16;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] dwell;
    logic [15:0] value;
  } entry_t;

  typedef struct packed {
    logic [3:0] last_idx;
    logic       loop;
    logic       enable;
  } ctrl_t;

  // A dwell of zero still holds the entry for one cycle.
  function automatic logic [15:0] load_count(input logic [15:0] dwell);
    return (dwell == 16'd0) ? 16'd0 : dwell - 16'd1;
  endfunction

endpackage

// File: rtl/io_seq_gen_if.sv
// Serial register bus, trigger and bank-output signals of one io_seq_gen instance.
interface io_seq_gen_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        trigger;
  logic [15:0] reg_out;
  logic        busy;
  logic [3:0]  step_idx;
  logic        done;

  modport master (
    output serial_addr, serial_data, serial_strobe, trigger,
    input  reg_out, busy, step_idx, done
  );

  modport slave (
    input  serial_addr, serial_data, serial_strobe, trigger,
    output reg_out, busy, step_idx, done
  );
endinterface

// File: rtl/io_seq_mem.sv
// Pattern table: synchronous write, asynchronous read so it maps onto distributed RAM.
// Contents are deliberately not reset.
module io_seq_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_seq_gen.sv
// Output value generator for one io_pins bank: a masked static value plus a
// triggered {dwell,value} pattern playback with optional looping.
module io_seq_gen
  import io_seq_gen_pkg::*;
#(
  parameter logic [6:0] ADDR_CTRL   = DEF_ADDR_CTRL,
  parameter logic [6:0] ADDR_STATIC = DEF_ADDR_STATIC,
  parameter logic [6:0] ADDR_WPTR   = DEF_ADDR_WPTR,
  parameter logic [6:0] ADDR_WDATA  = DEF_ADDR_WDATA
) (
  input logic         clock,
  input logic         reset,
  io_seq_gen_if.slave bus
);

  ctrl_t             ctrl;
  logic [15:0]       static_val;
  logic [IDX_W-1:0]  wptr;
  state_t            state;
  state_t            state_next;
  logic [15:0]       cnt;
  logic [15:0]       run_val;
  logic [IDX_W-1:0]  step;
  logic              done_q;
  logic              load;
  logic              finish;
  logic [IDX_W-1:0]  load_idx;
  logic              mem_we;
  logic [31:0]       rd_data;
  entry_t            rd_entry;

  assign mem_we   = bus.serial_strobe && (bus.serial_addr == ADDR_WDATA);
  assign rd_entry = entry_t'(rd_data);

  io_seq_mem #(.DEPTH(DEPTH), .WIDTH(32)) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (wptr),
    .wdata (bus.serial_data),
    .raddr (load_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl       <= '0;
      static_val <= '0;
      wptr       <= '0;
    end else if (bus.serial_strobe) begin
      if (bus.serial_addr == ADDR_CTRL) begin
        ctrl <= '{last_idx: bus.serial_data[7:4],
                  loop:     bus.serial_data[1],
                  enable:   bus.serial_data[0]};
      end else if (bus.serial_addr == ADDR_STATIC) begin
        static_val <= (static_val & ~bus.serial_data[31:16]) |
                      (bus.serial_data[15:0] & bus.serial_data[31:16]);
      end else if (bus.serial_addr == ADDR_WPTR) begin
        wptr <= bus.serial_data[IDX_W-1:0];
      end else if (bus.serial_addr == ADDR_WDATA) begin
        wptr <= wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus which table entry (if any) is loaded at this edge.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    load_idx   = '0;
    case (state)
      IDLE: begin
        if (ctrl.enable) state_next = ARMED;
      end
      ARMED: begin
        if (!ctrl.enable) begin
          state_next = IDLE;
        end else if (bus.trigger) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (!ctrl.enable) begin
          state_next = IDLE;
        end else if (cnt == 16'd0) begin
          if (step != ctrl.last_idx) begin
            load     = 1'b1;
            load_idx = step + 1'b1;
          end else if (ctrl.loop) begin
            load = 1'b1;
          end else begin
            state_next = ARMED;
            finish     = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      run_val <= '0;
      step    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        run_val <= rd_entry.value;
        cnt     <= load_count(rd_entry.dwell);
        step    <= load_idx;
      end else if (state == RUN && cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  // Outside RUN the bank follows static_val directly, so static writes show up next cycle.
  always_comb begin
    bus.reg_out  = static_val;
    bus.busy     = 1'b0;
    bus.step_idx = '0;
    bus.done     = done_q;
    if (state == RUN) begin
      bus.reg_out  = run_val;
      bus.busy     = 1'b1;
      bus.step_idx = step;
    end
  end

endmodule
